microseq_ctrl: RTL and testbench



---
 rtl/microseq_pkg.sv | 44 ++++
 rtl/microseq_if.sv | 28 ++
 rtl/microseq_store.sv | 54 +++++
 rtl/microseq_ctrl.sv | 141 ++++++++++++++
 tb/tb_microseq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings and store-word layout for the microprogram sequencer.
package microseq_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned BR_W       = 3;
    localparam int unsigned WORD_W     = 7;
    localparam int unsigned IN_W       = 2;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned NUM_STATES = 1 << STATE_W;
    localparam int unsigned NUM_IN     = 1 << IN_W;

    // Store word layout: {branch, target}
    localparam int unsigned BR_MSB  = 6;
    localparam int unsigned BR_LSB  = 4;
    localparam int unsigned TGT_MSB = 3;
    localparam int unsigned TGT_LSB = 0;

    typedef enum logic [BR_W-1:0] {
        BR_SEQ   = 3'd0,
        BR_DISP1 = 3'd1,
        BR_DISP2 = 3'd2,
        BR_JUMP  = 3'd3,
        BR_JZ    = 3'd4,
        BR_CALL  = 3'd5,
        BR_RET   = 3'd6,
        BR_HALT  = 3'd7
    } branch_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_FAULT = 2'd2
    } mode_t;

    localparam logic [SEL_W-1:0] PSEL_STORE = 2'd0;
    localparam logic [SEL_W-1:0] PSEL_DISP1 = 2'd1;
    localparam logic [SEL_W-1:0] PSEL_DISP2 = 2'd2;

    typedef struct packed {
        branch_t               branch;
        logic [STATE_W-1:0]    target;
    } store_word_t;

endpackage

// File: rtl/microseq_if.sv
// Host/datapath-facing signal bundle of the microprogram sequencer.
interface microseq_if;
    import microseq_pkg::*;

    logic [IN_W-1:0]    in;
    logic               start;
    logic               halt_req;
    logic               prog_we;
    logic [SEL_W-1:0]   prog_sel;
    logic [STATE_W-1:0] prog_addr;
    logic [WORD_W-1:0]  prog_data;
    logic               prog_ack;
    logic [STATE_W-1:0] state;
    logic [BR_W-1:0]    uop_branch;
    logic               running;
    logic               fault;

    modport master (
        output in, start, halt_req, prog_we, prog_sel, prog_addr, prog_data,
        input  prog_ack, state, uop_branch, running, fault
    );

    modport slave (
        input  in, start, halt_req, prog_we, prog_sel, prog_addr, prog_data,
        output prog_ack, state, uop_branch, running, fault
    );

endinterface

// File: rtl/microseq_store.sv
// Writable control store (16 words) and two input-indexed dispatch tables.
// Synchronous write and clear, asynchronous read.
module microseq_store
    import microseq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [SEL_W-1:0]   sel,
    input  logic [STATE_W-1:0] addr,
    input  logic [WORD_W-1:0]  data,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [IN_W-1:0]    rd_in,
    output store_word_t        word_c,
    output logic [STATE_W-1:0] disp1_c,
    output logic [STATE_W-1:0] disp2_c
);

    store_word_t        store_q [NUM_STATES];
    logic [STATE_W-1:0] disp1_q [NUM_IN];
    logic [STATE_W-1:0] disp2_q [NUM_IN];
    store_word_t        wr_word;

    // Unpack the programming word into the store layout
    always_comb begin
        wr_word        = '0;
        wr_word.branch = branch_t'(data[BR_MSB:BR_LSB]);
        wr_word.target = data[TGT_MSB:TGT_LSB];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                store_q[i] <= '0;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                disp1_q[i] <= '0;
                disp2_q[i] <= '0;
            end
        end else if (we) begin
            case (sel)
                PSEL_STORE: store_q[addr]                <= wr_word;
                PSEL_DISP1: disp1_q[IN_W'(addr)]         <= data[TGT_MSB:TGT_LSB];
                PSEL_DISP2: disp2_q[IN_W'(addr)]         <= data[TGT_MSB:TGT_LSB];
                default: ;
            endcase
        end
    end

    assign word_c  = store_q[rd_state];
    assign disp1_c = disp1_q[rd_in];
    assign disp2_c = disp2_q[rd_in];

endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: mode FSM, next-state selection and return stack
// wrapped around the writable control store.
module microseq_ctrl
    import microseq_pkg::*;
#(
    parameter logic [STATE_W-1:0] START_STATE = 4'd0,
    parameter int unsigned        STACK_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    microseq_if.slave  bus
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    mode_t              mode_q, mode_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [STATE_W-1:0] stack_q [STACK_DEPTH];
    logic               push;
    logic               prog_ack_q;
    logic               running_q;
    logic               fault_q;

    logic               wr_en;
    store_word_t        word_c;
    logic [STATE_W-1:0] disp1_c;
    logic [STATE_W-1:0] disp2_c;
    logic [STATE_W-1:0] seq_next;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic               stack_full;
    logic               stack_empty;

    // Programming is only accepted while idle and to a defined table
    assign wr_en = bus.prog_we && (mode_q == MODE_IDLE) &&
                   (bus.prog_sel inside {PSEL_STORE, PSEL_DISP1, PSEL_DISP2});

    microseq_store u_store (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .sel      (bus.prog_sel),
        .addr     (bus.prog_addr),
        .data     (bus.prog_data),
        .rd_state (state_q),
        .rd_in    (bus.in),
        .word_c   (word_c),
        .disp1_c  (disp1_c),
        .disp2_c  (disp2_c)
    );

    assign seq_next    = state_q + STATE_W'(1);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_IDLE;
            state_q    <= '0;
            sp_q       <= '0;
            prog_ack_q <= 1'b0;
            running_q  <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            mode_q     <= mode_d;
            state_q    <= state_d;
            sp_q       <= sp_d;
            prog_ack_q <= wr_en;
            running_q  <= (mode_d == MODE_RUN);
            fault_q    <= (mode_d == MODE_FAULT);
            if (push) begin
                stack_q[push_idx] <= seq_next;
            end
        end
    end

    // Mode transitions and microinstruction decode
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        sp_d    = sp_q;
        push    = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                if (bus.start) begin
                    mode_d  = MODE_RUN;
                    state_d = START_STATE;
                    sp_d    = '0;
                end
            end
            MODE_RUN: begin
                if (bus.halt_req) begin
                    mode_d = MODE_IDLE;
                end else begin
                    case (word_c.branch)
                        BR_SEQ:   state_d = seq_next;
                        BR_DISP1: state_d = disp1_c;
                        BR_DISP2: state_d = disp2_c;
                        BR_JUMP:  state_d = word_c.target;
                        BR_JZ:    state_d = (bus.in == '0) ? word_c.target : seq_next;
                        BR_CALL: begin
                            if (stack_full) begin
                                mode_d = MODE_FAULT;
                            end else begin
                                push    = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                state_d = word_c.target;
                            end
                        end
                        BR_RET: begin
                            if (stack_empty) begin
                                mode_d = MODE_FAULT;
                            end else begin
                                sp_d    = sp_q - SP_W'(1);
                                state_d = stack_q[top_idx];
                            end
                        end
                        BR_HALT:  mode_d = MODE_IDLE;
                        default:  mode_d = MODE_FAULT;
                    endcase
                end
            end
            MODE_FAULT: ;
            default: mode_d = MODE_IDLE;
        endcase
    end

    assign bus.prog_ack   = prog_ack_q;
    assign bus.state      = state_q;
    assign bus.uop_branch = word_c.branch;
    assign bus.running    = running_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl: directed stimulus queues the expected
// outputs per cycle, a negedge monitor compares them against the DUT.
module tb_microseq_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic       run;
        logic       flt;
        logic       ack;
        int         br;
        string      nm;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   br_exp;
    exp_t sb[$];

    microseq_if bus();

    microseq_ctrl #(
        .START_STATE (4'd0),
        .STACK_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || bus.state !== e.st || bus.running !== e.run ||
                bus.fault !== e.flt || bus.prog_ack !== e.ack ||
                (e.br >= 0 && int'(bus.uop_branch) != e.br)) begin
                failures = failures + 1;
                $display("FAIL %s cyc=%0d/%0d state=%0d/%0d running=%0b/%0b fault=%0b/%0b prog_ack=%0b/%0b uop_branch=%0d/%0d (got/exp)",
                         e.nm, cyc, e.cyc, bus.state, e.st, bus.running, e.run,
                         bus.fault, e.flt, bus.prog_ack, e.ack, bus.uop_branch, e.br);
            end
        end
    end

    // Queue the expected outputs after the next edge, then advance one cycle
    task automatic tick(input logic [3:0] es, input logic er, input logic ef,
                        input logic ea, input string nm);
        exp_t e;
        e.cyc = cyc + 1;
        e.st  = es;
        e.run = er;
        e.flt = ef;
        e.ack = ea;
        e.br  = br_exp;
        e.nm  = nm;
        sb.push_back(e);
        br_exp = -1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.halt_req = 1'b0;
        bus.prog_we  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [3:0] a, input logic [6:0] d,
                      input logic [3:0] es, input string nm);
        bus.prog_we   = 1'b1;
        bus.prog_sel  = s;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick(es, 1'b0, 1'b0, 1'b1, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        br_exp = -1;
        reset = 1'b1;
        bus.in = 2'd0;
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_sel = 2'd0;
        bus.prog_addr = 4'd0;
        bus.prog_data = 7'd0;
        @(posedge clk);
        #1;
        tick(4'd0, 0, 0, 0, "reset");
        reset = 1'b0;

        // Reset clears a programmed word: step from 5 must be SEQ
        wr(2'd0, 4'd5, 7'h33, 4'd0, "wr_s5");
        tick(4'd0, 0, 0, 0, "ack_drop");
        reset = 1'b1;
        tick(4'd0, 0, 0, 0, "reset_clear");
        reset = 1'b0;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "start");
        for (int i = 1; i <= 6; i++) tick(4'(i), 1, 0, 0, "seq_cleared");
        bus.halt_req = 1'b1;
        tick(4'd6, 0, 0, 0, "halt6");

        // Sequential and jump loop
        wr(2'd0, 4'd0, 7'h00, 4'd6, "wr_s0");
        wr(2'd0, 4'd1, 7'h00, 4'd6, "wr_s1");
        wr(2'd0, 4'd2, 7'h30, 4'd6, "wr_s2");
        tick(4'd6, 0, 0, 0, "ack_once");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "loop0");
        tick(4'd1, 1, 0, 0, "loop1");
        tick(4'd2, 1, 0, 0, "loop2");
        tick(4'd0, 1, 0, 0, "loop_jump");
        tick(4'd1, 1, 0, 0, "loop1b");
        bus.halt_req = 1'b1;
        tick(4'd1, 0, 0, 0, "halt1");

        // SEQ wraps 15 -> 0
        wr(2'd0, 4'd0, 7'h3F, 4'd1, "wr_j15");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "wrap_start");
        tick(4'd15, 1, 0, 0, "jump15");
        tick(4'd0, 1, 0, 0, "seq_wrap");
        bus.halt_req = 1'b1;
        tick(4'd0, 0, 0, 0, "halt0");

        // Dispatch tables
        wr(2'd0, 4'd0, 7'h10, 4'd0, "wr_disp1_op");
        for (int i = 0; i < 4; i++) wr(2'd1, 4'(i), 7'(5 + i), 4'd0, "wr_disp1_tbl");
        bus.in = 2'd2;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "disp1_start");
        tick(4'd7, 1, 0, 0, "disp1");
        bus.halt_req = 1'b1;
        tick(4'd7, 0, 0, 0, "halt7");
        wr(2'd0, 4'd0, 7'h20, 4'd7, "wr_disp2_op");
        wr(2'd2, 4'd3, 7'h0B, 4'd7, "wr_disp2_tbl");
        bus.in = 2'd3;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "disp2_start");
        tick(4'd11, 1, 0, 0, "disp2");
        bus.halt_req = 1'b1;
        tick(4'd11, 0, 0, 0, "halt11");
        bus.prog_we = 1'b1;
        bus.prog_sel = 2'd3;
        bus.prog_addr = 4'd0;
        bus.prog_data = 7'h30;
        tick(4'd11, 0, 0, 0, "psel3_noack");

        // Conditional branch
        wr(2'd0, 4'd0, 7'h49, 4'd11, "wr_jz");
        bus.in = 2'd0;
        bus.start = 1'b1;
        br_exp = 4;
        tick(4'd0, 1, 0, 0, "jz_start");
        tick(4'd9, 1, 0, 0, "jz_taken");
        bus.halt_req = 1'b1;
        tick(4'd9, 0, 0, 0, "halt9");
        bus.in = 2'd1;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "jz_start2");
        tick(4'd1, 1, 0, 0, "jz_not_taken");
        bus.halt_req = 1'b1;
        tick(4'd1, 0, 0, 0, "halt1b");

        // Call / return
        wr(2'd0, 4'd0, 7'h54, 4'd1, "wr_call4");
        wr(2'd0, 4'd4, 7'h60, 4'd1, "wr_ret");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "call_start");
        br_exp = 6;
        tick(4'd4, 1, 0, 0, "call");
        tick(4'd1, 1, 0, 0, "ret");
        bus.halt_req = 1'b1;
        tick(4'd1, 0, 0, 0, "halt_after_ret");
        wr(2'd0, 4'd4, 7'h58, 4'd1, "wr_call8");
        wr(2'd0, 4'd8, 7'h5C, 4'd1, "wr_call12");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "chain_start");
        tick(4'd4, 1, 0, 0, "call_d1");
        tick(4'd8, 1, 0, 0, "call_d2");
        tick(4'd8, 0, 1, 0, "call_overflow");
        bus.start = 1'b1;
        tick(4'd8, 0, 1, 0, "fault_start_ign");
        bus.prog_we = 1'b1;
        bus.prog_sel = 2'd0;
        tick(4'd8, 0, 1, 0, "fault_we_ign");
        reset = 1'b1;
        tick(4'd0, 0, 0, 0, "fault_reset");
        reset = 1'b0;
        wr(2'd0, 4'd0, 7'h60, 4'd0, "wr_ret_empty");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "ret_start");
        tick(4'd0, 0, 1, 0, "ret_underflow");
        reset = 1'b1;
        tick(4'd0, 0, 0, 0, "fault_reset2");
        reset = 1'b0;

        // Halt request, writes during RUN, HALT instruction
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "h_start");
        for (int i = 1; i <= 3; i++) tick(4'(i), 1, 0, 0, "h_seq");
        bus.halt_req = 1'b1;
        tick(4'd3, 0, 0, 0, "halt_req3");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "we_start");
        bus.prog_we = 1'b1;
        bus.prog_sel = 2'd0;
        bus.prog_addr = 4'd1;
        bus.prog_data = 7'h39;
        tick(4'd1, 1, 0, 0, "run_we_noack");
        tick(4'd2, 1, 0, 0, "run_we_ignored");
        bus.halt_req = 1'b1;
        tick(4'd2, 0, 0, 0, "halt2");
        wr(2'd0, 4'd2, 7'h70, 4'd2, "wr_halt");
        bus.halt_req = 1'b1;
        tick(4'd2, 0, 0, 0, "idle_halt_ign");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "hi_start");
        tick(4'd1, 1, 0, 0, "hi_1");
        br_exp = 7;
        tick(4'd2, 1, 0, 0, "hi_2");
        tick(4'd2, 0, 0, 0, "halt_instr");

        // Write and start in the same cycle
        bus.prog_we = 1'b1;
        bus.prog_sel = 2'd0;
        bus.prog_addr = 4'd0;
        bus.prog_data = 7'h35;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 1, "wr_and_start");
        tick(4'd5, 1, 0, 0, "new_contents");
        bus.halt_req = 1'b1;
        tick(4'd5, 0, 0, 0, "halt5");

        // Reset in the middle of a run
        reset = 1'b1;
        tick(4'd0, 0, 0, 0, "pre_reset");
        reset = 1'b0;
        wr(2'd0, 4'd3, 7'h36, 4'd0, "wr_j6");
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "mr_start");
        for (int i = 1; i <= 3; i++) tick(4'(i), 1, 0, 0, "mr_seq");
        tick(4'd6, 1, 0, 0, "mr_jump6");
        reset = 1'b1;
        tick(4'd0, 0, 0, 0, "mid_reset");
        reset = 1'b0;
        bus.start = 1'b1;
        tick(4'd0, 1, 0, 0, "post_start");
        for (int i = 1; i <= 3; i++) tick(4'(i), 1, 0, 0, "post_seq");
        tick(4'd4, 1, 0, 0, "store_cleared");
        bus.halt_req = 1'b1;
        tick(4'd4, 0, 0, 0, "halt4");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
